// File: rtl/fft_butterfly_pipe.sv
// Four-stage radix-2 DIT butterfly: X = A + W*B, Y = A - W*B with valid/ready flow control,
// per-sample conjugate twiddle, optional divide-by-2 and saturating outputs with a sticky flag.
`default_nettype none

module fft_butterfly_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int TW_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_re,
  input  logic [DATA_WIDTH-1:0] a_im,
  input  logic [DATA_WIDTH-1:0] b_re,
  input  logic [DATA_WIDTH-1:0] b_im,
  input  logic [TW_WIDTH-1:0]   w_re,
  input  logic [TW_WIDTH-1:0]   w_im,
  input  logic                  inv,
  input  logic                  scale,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] x_re,
  output logic [DATA_WIDTH-1:0] x_im,
  output logic [DATA_WIDTH-1:0] y_re,
  output logic [DATA_WIDTH-1:0] y_im,
  output logic                  ovf,
  output logic                  ovf_sticky,
  input  logic                  ovf_clr
);

  localparam int DW  = DATA_WIDTH;
  localparam int TW  = TW_WIDTH;
  localparam int PW  = DW + TW;      // full product
  localparam int SW  = PW + 1;       // product sum
  localparam int TDW = DW + 2;       // rounded twiddled product
  localparam int XW  = DW + 3;       // butterfly sum before saturation

  localparam logic signed [SW-1:0] RND     = {{(SW-1){1'b0}}, 1'b1} << (TW - 2);
  localparam logic signed [XW-1:0] SAT_MAX = {4'b0000, {(DW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {4'b1111, {(DW-1){1'b0}}};

  logic stall;
  logic adv;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  // Round half up on the Q1.(TW-1) product, keeping only the significant DW+2 bits.
  function automatic logic signed [TDW-1:0] round_tw(input logic signed [SW-1:0] p);
    logic signed [SW-1:0] r;
    r = (p + RND) >>> (TW - 1);
    return r[TDW-1:0];
  endfunction

  // Returns {saturated, value} for one output component.
  function automatic logic [DW:0] bfly_out(input logic signed [DW-1:0]  a,
                                           input logic signed [TDW-1:0] t,
                                           input logic                  sub,
                                           input logic                  sc);
    logic signed [XW-1:0] v;
    logic [DW:0]          res;
    v = sub ? (XW'(a) - XW'(t)) : (XW'(a) + XW'(t));
    if (sc) v = (v + XW'(1)) >>> 1;
    if (v > SAT_MAX)      res = {1'b1, SAT_MAX[DW-1:0]};
    else if (v < SAT_MIN) res = {1'b1, SAT_MIN[DW-1:0]};
    else                  res = {1'b0, v[DW-1:0]};
    return res;
  endfunction

  // S1: input capture
  logic                  s1_valid, s1_inv, s1_scale;
  logic signed [DW-1:0]  s1_a_re, s1_a_im, s1_b_re, s1_b_im;
  logic signed [TW-1:0]  s1_w_re, s1_w_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_inv   <= 1'b0;
      s1_scale <= 1'b0;
      s1_a_re  <= '0;
      s1_a_im  <= '0;
      s1_b_re  <= '0;
      s1_b_im  <= '0;
      s1_w_re  <= '0;
      s1_w_im  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_inv   <= inv;
      s1_scale <= scale;
      s1_a_re  <= a_re;
      s1_a_im  <= a_im;
      s1_b_re  <= b_re;
      s1_b_im  <= b_im;
      s1_w_re  <= w_re;
      s1_w_im  <= w_im;
    end
  end

  // S2: four full-width products
  logic                  s2_valid, s2_inv, s2_scale;
  logic signed [DW-1:0]  s2_a_re, s2_a_im;
  logic signed [PW-1:0]  s2_brwr, s2_biwi, s2_biwr, s2_brwi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_inv   <= 1'b0;
      s2_scale <= 1'b0;
      s2_a_re  <= '0;
      s2_a_im  <= '0;
      s2_brwr  <= '0;
      s2_biwi  <= '0;
      s2_biwr  <= '0;
      s2_brwi  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_inv   <= s1_inv;
      s2_scale <= s1_scale;
      s2_a_re  <= s1_a_re;
      s2_a_im  <= s1_a_im;
      s2_brwr  <= PW'(s1_b_re) * PW'(s1_w_re);
      s2_biwi  <= PW'(s1_b_im) * PW'(s1_w_im);
      s2_biwr  <= PW'(s1_b_im) * PW'(s1_w_re);
      s2_brwi  <= PW'(s1_b_re) * PW'(s1_w_im);
    end
  end

  // S3: combine products (conjugating W in inverse mode) and round
  logic signed [SW-1:0]  pr_sum, pi_sum;

  always_comb begin
    if (s2_inv) begin
      pr_sum = SW'(s2_brwr) + SW'(s2_biwi);
      pi_sum = SW'(s2_biwr) - SW'(s2_brwi);
    end else begin
      pr_sum = SW'(s2_brwr) - SW'(s2_biwi);
      pi_sum = SW'(s2_biwr) + SW'(s2_brwi);
    end
  end

  logic                  s3_valid, s3_scale;
  logic signed [DW-1:0]  s3_a_re, s3_a_im;
  logic signed [TDW-1:0] s3_t_re, s3_t_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_scale <= 1'b0;
      s3_a_re  <= '0;
      s3_a_im  <= '0;
      s3_t_re  <= '0;
      s3_t_im  <= '0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      s3_scale <= s2_scale;
      s3_a_re  <= s2_a_re;
      s3_a_im  <= s2_a_im;
      s3_t_re  <= round_tw(pr_sum);
      s3_t_im  <= round_tw(pi_sum);
    end
  end

  // S4: butterfly sums, optional halving, saturation
  logic [DW:0] xr_n, xi_n, yr_n, yi_n;
  logic        ovf_n;

  assign xr_n  = bfly_out(s3_a_re, s3_t_re, 1'b0, s3_scale);
  assign xi_n  = bfly_out(s3_a_im, s3_t_im, 1'b0, s3_scale);
  assign yr_n  = bfly_out(s3_a_re, s3_t_re, 1'b1, s3_scale);
  assign yi_n  = bfly_out(s3_a_im, s3_t_im, 1'b1, s3_scale);
  assign ovf_n = xr_n[DW] | xi_n[DW] | yr_n[DW] | yi_n[DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      x_re       <= '0;
      x_im       <= '0;
      y_re       <= '0;
      y_im       <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (adv) begin
        out_valid <= s3_valid;
        if (s3_valid) begin
          x_re <= xr_n[DW-1:0];
          x_im <= xi_n[DW-1:0];
          y_re <= yr_n[DW-1:0];
          y_im <= yi_n[DW-1:0];
          ovf  <= ovf_n;
        end
      end
      // A new overflow loaded this edge takes priority over a clear request.
      if (adv && s3_valid && ovf_n) ovf_sticky <= 1'b1;
      else if (ovf_clr)             ovf_sticky <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_butterfly_pipe.sv
// Bench for fft_butterfly_pipe: directed vector table, overflow/clear sequences,
// randomized backpressured stream against an arithmetic reference, and mid-flight reset.
`default_nettype none

module tb_fft_butterfly_pipe;

  localparam int DW = 16;
  localparam int TW = 16;
  localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (DW - 1));

  typedef struct {
    int a_re, a_im, b_re, b_im, w_re, w_im;
    bit inv, scale;
    int x_re, x_im, y_re, y_im;
    bit ovf;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic [TW-1:0] w_re = '0, w_im = '0;
  logic          inv = 1'b0, scale = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] x_re, x_im, y_re, y_im;
  logic          ovf, ovf_sticky;
  logic          ovf_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  fft_butterfly_pipe #(.DATA_WIDTH(DW), .TW_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im), .inv(inv), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im),
    .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat_comp(input longint v, input bit sc, inout bit o);
    if (sc) v = (v + 1) >>> 1;
    if (v > MAXV) begin o = 1'b1; return int'(MAXV); end
    if (v < MINV) begin o = 1'b1; return int'(MINV); end
    return int'(v);
  endfunction

  // Reference: complex multiply with optional conjugate, round, butterfly, scale, saturate.
  function automatic vec_t model(input vec_t v);
    longint pr, pi, tr, ti;
    bit o;
    vec_t r;
    r = v;
    if (v.inv) begin
      pr = longint'(v.b_re) * v.w_re + longint'(v.b_im) * v.w_im;
      pi = longint'(v.b_im) * v.w_re - longint'(v.b_re) * v.w_im;
    end else begin
      pr = longint'(v.b_re) * v.w_re - longint'(v.b_im) * v.w_im;
      pi = longint'(v.b_im) * v.w_re + longint'(v.b_re) * v.w_im;
    end
    tr = (pr + (longint'(1) <<< (TW - 2))) >>> (TW - 1);
    ti = (pi + (longint'(1) <<< (TW - 2))) >>> (TW - 1);
    o = 1'b0;
    r.x_re = sat_comp(longint'(v.a_re) + tr, v.scale, o);
    r.x_im = sat_comp(longint'(v.a_im) + ti, v.scale, o);
    r.y_re = sat_comp(longint'(v.a_re) - tr, v.scale, o);
    r.y_im = sat_comp(longint'(v.a_im) - ti, v.scale, o);
    r.ovf  = o;
    return r;
  endfunction

  function automatic int rnd16();
    logic [15:0] u;
    u = 16'($urandom);
    return int'($signed(u));
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.a_re = rnd16(); v.a_im = rnd16();
    v.b_re = rnd16(); v.b_im = rnd16();
    v.w_re = rnd16(); v.w_im = rnd16();
    v.inv = 1'($urandom_range(0, 1));
    v.scale = 1'($urandom_range(0, 1));
    return model(v);
  endfunction

  task automatic drive(input vec_t v);
    a_re = DW'(v.a_re); a_im = DW'(v.a_im);
    b_re = DW'(v.b_re); b_im = DW'(v.b_im);
    w_re = TW'(v.w_re); w_im = TW'(v.w_im);
    inv = v.inv; scale = v.scale;
  endtask

  task automatic check_out(input string tag, input vec_t e);
    check({tag, " x_re"}, $signed(x_re), e.x_re);
    check({tag, " x_im"}, $signed(x_im), e.x_im);
    check({tag, " y_re"}, $signed(y_re), e.y_re);
    check({tag, " y_im"}, $signed(y_im), e.y_im);
    check({tag, " ovf"}, ovf, e.ovf);
  endtask

  // Send one sample into an idle pipe, measure edges to out_valid, check results.
  // With clr_at_load, ovf_clr is held high across the edge that loads the output.
  task automatic run_one(input vec_t v, input bit clr_at_load, input string tag);
    int edges;
    bit got;
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    edges = 1;
    got = 1'b0;
    repeat (12) begin
      @(negedge clk);
      in_valid = 1'b0;
      ovf_clr = 1'b0;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      if (clr_at_load && edges == 3) ovf_clr = 1'b1;
      @(posedge clk);
      edges++;
    end
    check({tag, " latency"}, got ? edges : -1, 4);
    if (got) check_out(tag, v);
  endtask

  vec_t tbl[6];

  initial begin
    vec_t   cur, e;
    vec_t   expq[$];
    int     sent, rcvd, cyc;
    bit     prev_stall, stale;
    logic [63:0] held;

    tbl[0] = '{1000, 0, 500, 0, 32767, 0, 1'b0, 1'b0, 1500, 0, 500, 0, 1'b0};
    tbl[1] = '{1000, 0, 500, 0, 32767, 0, 1'b0, 1'b1, 750, 0, 250, 0, 1'b0};
    tbl[2] = '{0, 0, 100, 200, 0, -32768, 1'b0, 1'b0, 200, -100, -200, 100, 1'b0};
    tbl[3] = '{0, 0, 100, 200, 0, -32768, 1'b1, 1'b0, -200, 100, 200, -100, 1'b0};
    tbl[4] = '{32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0, 32767, 0, 1, 0, 1'b1};
    tbl[5] = '{32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b1, 32767, 0, 1, 0, 1'b0};

    // Reset state
    @(negedge clk);
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst x_re", x_re, 0);
    check("rst y_im", y_im, 0);
    check("rst ovf", ovf, 0);
    check("rst ovf_sticky", ovf_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready after reset", in_ready, 1);

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      run_one(tbl[i], 1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d ovf_sticky", i), ovf_sticky, (i >= 4) ? 1 : 0);
    end

    // Sticky clear pulse, then clear coincident with a new overflow
    @(negedge clk);
    ovf_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ovf_clr = 1'b0;
    check("sticky cleared", ovf_sticky, 0);
    run_one(tbl[4], 1'b1, "clr+ovf");
    check("sticky set beats clear", ovf_sticky, 1);

    // Randomized stream with random backpressure
    sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0; held = '0;
    cur = rand_vec();
    while (rcvd < 16 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) check("hold during stall", {x_re, x_im, y_re, y_im}, held);
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 16) begin
        drive(cur);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("in_ready vs stall", in_ready, (out_valid && !out_ready) ? 0 : 1);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected output", 1, 0);
        end else begin
          e = expq.pop_front();
          check_out($sformatf("stream%0d", rcvd), e);
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(cur);
        sent++;
        cur = rand_vec();
      end
      prev_stall = out_valid && !out_ready;
      held = {x_re, x_im, y_re, y_im};
    end
    check("stream received", rcvd, 16);
    in_valid = 1'b0;
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("stream no extra output", stale, 0);
    check("stream queue drained", expq.size(), 0);

    // Reset with three samples in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(rand_vec());
      in_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst outputs", {x_re, x_im, y_re, y_im}, 0);
    check("midrst ovf", ovf, 0);
    check("midrst ovf_sticky", ovf_sticky, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready after midrst", in_ready, 1);
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("no stale after reset", stale, 0);
    run_one(tbl[2], 1'b0, "post-reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_butterfly_pipe.md
Name: fft_butterfly_pipe

Overview:
Parametrised, fully pipelined radix-2 DIT butterfly. It computes X = A + W·B and Y = A − W·B on signed fixed-point complex samples, producing both outputs every cycle. It adds a valid/ready handshake with backpressure, per-sample inverse mode (conjugated twiddle), per-sample divide-by-2 scaling, and overflow saturation with a sticky flag. It is the building block the FFT stage controller instantiates per butterfly lane.

Parameters:
DATA_WIDTH, 16, bits per real/imag component of A, B, X, Y; signed two's complement.
TW_WIDTH, 16, bits per twiddle component; signed Q1.(TW_WIDTH-1); −1.0 is allowed, +1.0 is represented as 2^(TW_WIDTH-1)−1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
a_re, a_im  in  DATA_WIDTH each  operand A
b_re, b_im  in  DATA_WIDTH each  operand B
w_re, w_im  in  TW_WIDTH each  twiddle W
inv  in  1  1 = use conj(W) (inverse FFT); captured with the sample
scale  in  1  1 = divide X and Y by 2; captured with the sample
out_valid  out  1  X/Y valid
out_ready  in  1  downstream accepts X/Y
x_re, x_im, y_re, y_im  out  DATA_WIDTH each  results
ovf  out  1  this output sample saturated (qualified by out_valid)
ovf_sticky  out  1  any saturated sample since reset/clear
ovf_clr  in  1  synchronous clear of ovf_sticky

Behaviour:
- Reset is asynchronous, active-low, on clk/rst_n as already decided. While asserted: all stage valids = 0, out_valid = 0, x/y = 0, ovf = 0, ovf_sticky = 0. in_ready = 1 one cycle after deassertion.
- Pipeline has 4 register stages, each with its own valid bit:
  - S1: registers inputs, inv and scale.
  - S2: registers four full-width products.
  - S3: registers the rounded twiddled product T and A (delayed).
  - S4: output registers.
- Stall = out_valid & ~out_ready. When stall = 1, every stage holds. When stall = 0, all stages advance together and bubbles propagate as valid = 0.
- in_ready = ~stall, purely combinational. A sample is accepted on an edge where in_valid & in_ready. It appears on the outputs after the 4th edge (the accept edge plus 3 further edges) if no stall occurs. Throughput is 1 sample/cycle.
- Outputs are held stable while out_valid & ~out_ready.
- Arithmetic, forward mode (inv = 0):
  - pr = b_re·w_re − b_im·w_im
  - pi = b_im·w_re + b_re·w_im
- Arithmetic, inverse mode (inv = 1):
  - pr = b_re·w_re + b_im·w_im
  - pi = b_im·w_re − b_re·w_im
- Sums are DATA_WIDTH+TW_WIDTH+1 bits; no intermediate loss.
- T = (p + 2^(TW_WIDTH−2)) >>> (TW_WIDTH−1), arithmetic shift (round half up), kept at DATA_WIDTH+2 bits.
- X = A + T and Y = A − T at DATA_WIDTH+3 bits. If scale: v = (v + 1) >>> 1.
- Each of the four components then saturates to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- ovf = OR of the four saturation events for that sample, registered with it in S4.
- ovf_sticky:
  - Set on any output-register load with ovf = 1.
  - ovf_clr clears it.
  - If clear and set occur in the same cycle, set wins.
- Reset mid-operation: all in-flight samples are discarded, with no partial output.
- out_valid never asserts without a corresponding accepted input. No sample is duplicated or dropped under any out_ready pattern.

Test Plan:
1. DATA_WIDTH = TW_WIDTH = 16. A = (1000, 0), B = (500, 0), W = (32767, 0), inv = 0, scale = 0 → X = (1500, 0), Y = (500, 0), ovf = 0. out_valid rises after the 4th edge from accept.
2. Same operands with scale = 1 → X = (750, 0), Y = (250, 0).
3. A = (0, 0), B = (100, 200), W = (0, −32768):
   - inv = 0 → X = (200, −100), Y = (−200, 100).
   - Same operands with inv = 1 → X = (−200, 100), Y = (200, −100).
4. A = (32767, 0), B = (32767, 0), W = (32767, 0):
   - scale = 0 → X = (32767, 0) saturated, Y = (1, 0), ovf = 1, ovf_sticky = 1.
   - scale = 1 → X = (32767, 0), Y = (1, 0), ovf = 0.
   - ovf_clr pulse → ovf_sticky = 0. ovf_clr coincident with a new overflow → ovf_sticky stays 1.
5. Stream 16 back-to-back samples with random out_ready (≈50%):
   - Outputs match the reference model in order, with no loss or duplication.
   - in_ready = 0 exactly on stall cycles.
   - x/y stay stable while stalled.
6. Assert rst_n low with 3 samples in flight → out_valid = 0 and outputs = 0 immediately. After release, no stale samples emerge and a new sample completes with 4-edge latency.
